// File: rtl/dmux_stream_pkg.sv
// dmux_stream_pkg
// Shared constants for the 4-way streaming demultiplexer:
//   - lane index constants (a..d map to 0..3, matching the in_sel encoding)
//   - default data width and lane FIFO depth
//   - pointer-width helper derived from the FIFO depth
package dmux_stream_pkg;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;
  localparam int LANE_D = 3;
  localparam int NUM_LANES = 4;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 2;

  // Pointer width for a FIFO of the given depth; depth must be a power of two.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo
// Small synchronous FIFO buffering the words of one output lane.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset; empties the FIFO
//   push       write push_data this cycle (ignored while full)
//   push_data  word to write
//   full       count == DEPTH
//   pop        consumer takes the head this cycle (ignored while empty)
//   head_data  oldest entry, forced to 0 while empty
//   not_empty  count != 0
module lane_fifo
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);

  // A full FIFO refuses a push even if it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && not_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; head_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

  assign head_data = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dmux4way16_stream.sv
// dmux4way16_stream
// Steers a valid/ready word stream to one of four lanes (a..d) selected by
// in_sel; each lane has its own FIFO so a stalled consumer blocks only its lane.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_data, in_sel       word and destination lane (0=a .. 3=d)
//   in_valid, in_ready    producer handshake; in_ready = selected lane not full
//   out_a..out_d          head word of each lane, 0 when the lane is empty
//   out_valid, out_ready  per-lane consumer handshake (bit0 = a .. bit3 = d)
//   idle                  all lanes empty
module dmux4way16_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             idle
);

  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_ne;
  logic [NUM_LANES-1:0] push_en;
  logic [WIDTH-1:0]     head [NUM_LANES];

  // Ready depends only on the select and registered lane state.
  assign in_ready = !lane_full[in_sel];

  // One-hot push enable toward the selected lane on an accepted handshake.
  always_comb begin
    push_en = '0;
    if (in_valid && in_ready) push_en[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en[i]),
      .push_data (in_data),
      .full      (lane_full[i]),
      .pop       (out_ready[i]),
      .head_data (head[i]),
      .not_empty (lane_ne[i])
    );
  end

  assign out_a     = head[LANE_A];
  assign out_b     = head[LANE_B];
  assign out_c     = head[LANE_C];
  assign out_d     = head[LANE_D];
  assign out_valid = lane_ne;
  assign idle      = (lane_ne == '0);

endmodule

// File: tb/tb_dmux4way16_stream.sv
// tb_dmux4way16_stream
// Drives directed and random traffic into dmux4way16_stream and compares every
// cycle against a queue-per-lane reference model of the stream behaviour.
module tb_dmux4way16_stream;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [15:0] out_c;
  logic [15:0] out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        idle;

  int vectors;
  int miscompares;

  // Reference model: one FIFO queue per lane.
  logic [15:0] model_q [4][$];

  dmux4way16_stream #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] lane_out(input int i);
    case (i)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  // Compare all registered outputs with the model's queues.
  task automatic checkState();
    logic [3:0] exp_valid;
    exp_valid = '0;
    for (int i = 0; i < 4; i++) begin
      exp_valid[i] = (model_q[i].size() > 0);
      checkOutput($sformatf("out_lane%0d", i), 32'(lane_out(i)),
                  exp_valid[i] ? 32'(model_q[i][0]) : 32'h0);
    end
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    checkOutput("idle", 32'(idle), 32'(exp_valid == 4'b0000));
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, update model, check state.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] sel,
                               input logic [15:0] data, input logic [3:0] rdy);
    logic exp_ready;
    logic push_ok;
    reset     = rst;
    in_valid  = valid;
    in_sel    = sel;
    in_data   = data;
    out_ready = rdy;
    #1;
    exp_ready = (model_q[sel].size() != DEPTH);
    if (!rst) checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    push_ok = valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) model_q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (rdy[i] && model_q[i].size() > 0) void'(model_q[i].pop_front());
      if (push_ok) model_q[sel].push_back(data);
    end
    #1;
    checkState();
  endtask

  task automatic idleCycles(input int n, input logic [3:0] rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, rdy);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 16'h0;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'b0000);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

    // One word per lane, consumers stalled
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h1111, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h2222, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h3333, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'h4444, 4'b0000);
    checkOutput("all_valid", 32'(out_valid), 32'hF);
    idleCycles(1, 4'b1111);

    // Lane c full, third push refused, lane a still ready
    applyStimulus(1'b0, 1'b1, 2'd2, 16'hA001, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'hA002, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'hA003, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h5555, 4'b0000);

    // Drain lane c in order, then everything
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'b0100);
    checkOutput("drain_c2", 32'(out_c), 32'hA002);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'b0100);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'b0100);
    idleCycles(1, 4'b1111);

    // Lane b push+pop at count 1 through pointer wrap
    applyStimulus(1'b0, 1'b1, 2'd1, 16'hB0B0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'hB1B1, 4'b0010);
    checkOutput("b_pushpop", 32'(out_b), 32'hB1B1);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b0, 1'b1, 2'd1, 16'hB200 + 16'(k), 4'b0010);
    idleCycles(1, 4'b1111);

    // Lane d full refuses a push even while popping
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hD001, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hD002, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hD003, 4'b1000);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hD004, 4'b0000);
    idleCycles(3, 4'b1111);

    // Reset mid-stream with three lanes occupied
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hC0DE, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'hBEEF, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hF00D, 4'b0000);
    applyStimulus(1'b1, 1'b1, 2'd2, 16'h9999, 4'b1111);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h7777, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h8888, 4'b0000);
    idleCycles(2, 4'b1111);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    16'($urandom),
                    4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
